cpu_req_queue: RTL and testbench
================================

# cpu_req_queue

Request queue between the CPU-side interface and the DDR3 controller. It accepts CPU read/write requests on a valid/ready handshake and buffers them in a strict-order FIFO. Requests are presented to the controller on a second valid/ready handshake. Reads are throttled by an outstanding-read counter so the controller's read-return path is never oversubscribed.

## Interface
Parameters:
- ADDR_W, 27, request address width (bank 3 + row 14 + column 10)
- DATA_W, 64, write data width
- DEPTH, 8, FIFO entries; power of two, ≥2
- MAX_RD_OUT, 4, maximum reads issued to the controller and not yet completed; ≥1

Ports:
- i_cpu_ck  in  1  system clock; all logic on rising edge
- i_cpu_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  CPU request valid
- o_req_ready  out  1  queue can accept a request
- i_req_wr  in  1  1 = write, 0 = read
- i_req_addr  in  ADDR_W  request address
- i_req_wdata  in  DATA_W  write data; ignored for reads
- o_ctl_valid  out  1  request presented to the controller
- i_ctl_ready  in  1  controller accepts the presented request
- o_ctl_wr  out  1  presented request type
- o_ctl_addr  out  ADDR_W  presented address
- o_ctl_wdata  out  DATA_W  presented write data
- i_rd_done  in  1  one-cycle pulse: controller returned data for one read
- o_count  out  $clog2(DEPTH+1)  entries currently stored
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0
- o_rd_out  out  $clog2(MAX_RD_OUT+1)  outstanding read count
- o_rd_err  out  1  sticky: i_rd_done arrived with o_rd_out == 0

## Operation
- **Push:** occurs when i_req_valid && o_req_ready. o_req_ready = !o_full, which is registered-state derived and independent of i_req_valid. The entry {wr, addr, wdata} is written at the write pointer.
- **Head:** the entry at the read pointer. head_blocked = head is a read && o_rd_out == MAX_RD_OUT.
- **o_ctl_valid:** = !o_empty && !head_blocked.
- **Blocking:** strict in-order issue. A blocked read also holds back every write behind it (head-of-line blocking by design).
- **Pop:** occurs when o_ctl_valid && i_ctl_ready.
- **o_ctl_wr/addr/wdata:** equal the head fields when o_ctl_valid = 1; forced to 0 otherwise.
- **Pointers:** log2(DEPTH) bits each, wrapping naturally. o_count is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- **Outstanding reads:** inc = pop of a read; dec = i_rd_done && o_rd_out != 0.
  - o_rd_out += inc − dec.
  - Simultaneous inc and dec: unchanged.
  - i_rd_done with o_rd_out == 0: counter stays 0 and o_rd_err is set. o_rd_err clears only on reset.
- **Controller-side rule:** the controller must not lower i_ctl_ready based on o_ctl_wr/addr combinationally in a way that loops back. o_ctl_valid does not depend on i_ctl_ready.
- **Reset (i_cpu_reset = 1 at a clock edge):**
  - Pointers, o_count, o_rd_out and o_rd_err go to 0.
  - Stored entries are discarded, including any mid-transfer.
  - Reset values: o_req_ready = 1, o_ctl_valid = 0, o_ctl_wr = 0, o_ctl_addr = 0, o_ctl_wdata = 0, o_count = 0, o_full = 0, o_empty = 1, o_rd_out = 0, o_rd_err = 0.
  - Storage RAM contents need not be cleared.

## Timing
- **Fill-through latency (bypass disabled):** a request pushed at edge N into an empty queue is presented with o_ctl_valid = 1 in the cycle after edge N. Minimum latency is 1 cycle.
- **Throughput:** one push and one pop per cycle, sustained.
- **Full queue:** o_req_ready = 0. A pop in that cycle does not make o_req_ready high in the same cycle; it rises after the edge.
- **Read unblocking:** a read blocked at MAX_RD_OUT unblocks the cycle after the edge at which i_rd_done is sampled. There is no same-cycle lookahead.
- **Status outputs:** o_count, o_full, o_empty and o_rd_out are registered-state values that reflect the previous edge.

## Configuration
- **CPU_REQ_BYPASS_EN defined:**
  - Applies when o_empty = 1, i_req_valid = 1, and the incoming request is not itself blocked (it is a write, or o_rd_out < MAX_RD_OUT).
  - o_ctl_valid = 1 and o_ctl_* are driven combinationally from i_req_*.
  - If i_ctl_ready = 1, the request is consumed that cycle and not stored; o_count stays 0. A read still increments o_rd_out.
  - If i_ctl_ready = 0, the request is stored normally.
  - Latency is 0 cycles.
- **Not defined:** no combinational input-to-output path. Every request passes through storage, with 1-cycle minimum latency.

## Test plan
- **Reset then fill:** 8 writes, addr 0x0..0x7, i_ctl_ready = 0 → o_full = 1 after the 8th edge and o_req_ready = 0. Then raise i_ctl_ready → 8 pops in order 0x0..0x7 over 8 cycles, after which o_empty = 1.
- **Read throttle:** 6 reads with MAX_RD_OUT = 4, i_ctl_ready = 1, no i_rd_done → 4 issued, o_rd_out = 4, o_ctl_valid = 0 with o_count = 2. Pulse i_rd_done once → the 5th read is issued on the following cycle.
- **Head-of-line blocking:** read blocked at head, with a write 0xABCD behind it → the write is not presented until the read issues.
- **Simultaneous events:** push and pop in the same cycle at o_count = 3 → o_count stays 3. Read issue and i_rd_done in the same cycle → o_rd_out unchanged.
- **Wrap and error:** 20 interleaved push/pop cycles wrapping the pointers → output order matches a reference queue. i_rd_done with o_rd_out = 0 → o_rd_err = 1 and held until reset.
- **Bypass (CPU_REQ_BYPASS_EN):** empty queue, write to 0x100 with i_ctl_ready = 1 → o_ctl_valid = 1 with o_ctl_addr = 0x100 in the same cycle, and o_count stays 0. Reset asserted with 3 entries stored → o_empty = 1 and o_ctl_valid = 0 next cycle.

Source files
------------

// File: rtl/cpu_req_queue.sv
// cpu_req_queue: strict-order request FIFO between the CPU-side interface and
// the DDR3 controller. Reads are throttled by an outstanding-read counter.
// Optional feature: define CPU_REQ_BYPASS_EN for a 0-cycle empty-queue bypass.
module cpu_req_queue #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8,
  parameter int MAX_RD_OUT = 4
) (
  input  logic                            i_cpu_ck,
  input  logic                            i_cpu_reset,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_wr,
  input  logic [ADDR_W-1:0]               i_req_addr,
  input  logic [DATA_W-1:0]               i_req_wdata,
  output logic                            o_ctl_valid,
  input  logic                            i_ctl_ready,
  output logic                            o_ctl_wr,
  output logic [ADDR_W-1:0]               o_ctl_addr,
  output logic [DATA_W-1:0]               o_ctl_wdata,
  input  logic                            i_rd_done,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(MAX_RD_OUT+1)-1:0] o_rd_out,
  output logic                            o_rd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RD_W  = $clog2(MAX_RD_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [RD_W-1:0]  RD_MAX   = RD_W'(MAX_RD_OUT);

  logic              mem_wr    [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [RD_W-1:0]  rd_out;
  logic             rd_err;

  logic head_blocked;
  logic fifo_valid;
  logic bypass;
  logic push;
  logic store;
  logic pop_fifo;
  logic rd_inc;
  logic rd_dec;

  assign o_count     = count;
  assign o_full      = (count == CNT_FULL);
  assign o_empty     = (count == '0);
  assign o_req_ready = !o_full;
  assign o_rd_out    = rd_out;
  assign o_rd_err    = rd_err;

  // Head selection, blocking, output muxing and per-cycle push/pop decisions
  always_comb begin
    head_blocked = !mem_wr[rd_ptr] && (rd_out == RD_MAX);
    fifo_valid   = !o_empty && !head_blocked;
    push         = i_req_valid && o_req_ready;
    bypass       = 1'b0;
    store        = push;
    pop_fifo     = 1'b0;
    o_ctl_valid  = 1'b0;
    o_ctl_wr     = 1'b0;
    o_ctl_addr   = '0;
    o_ctl_wdata  = '0;
`ifdef CPU_REQ_BYPASS_EN
    bypass = o_empty && i_req_valid && (i_req_wr || (rd_out < RD_MAX));
`endif
    if (bypass) begin
      // Incoming request goes straight out; it is stored only if not taken now
      o_ctl_valid = 1'b1;
      o_ctl_wr    = i_req_wr;
      o_ctl_addr  = i_req_addr;
      o_ctl_wdata = i_req_wdata;
      store       = push && !i_ctl_ready;
    end else if (fifo_valid) begin
      o_ctl_valid = 1'b1;
      o_ctl_wr    = mem_wr[rd_ptr];
      o_ctl_addr  = mem_addr[rd_ptr];
      o_ctl_wdata = mem_wdata[rd_ptr];
      pop_fifo    = i_ctl_ready;
    end
    rd_inc = o_ctl_valid && i_ctl_ready && !o_ctl_wr;
    rd_dec = i_rd_done && (rd_out != '0);
  end

  // Entry storage; contents are not cleared by reset
  always_ff @(posedge i_cpu_ck) begin
    if (store) begin
      mem_wr[wr_ptr]    <= i_req_wr;
      mem_addr[wr_ptr]  <= i_req_addr;
      mem_wdata[wr_ptr] <= i_req_wdata;
    end
  end

  // Pointers, occupancy, outstanding-read counter and sticky error flag
  always_ff @(posedge i_cpu_ck) begin
    if (i_cpu_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_out <= '0;
      rd_err <= 1'b0;
    end else begin
      if (store)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      if (store && !pop_fifo)      count <= count + CNT_W'(1);
      else if (!store && pop_fifo) count <= count - CNT_W'(1);
      if (rd_inc && !rd_dec)      rd_out <= rd_out + RD_W'(1);
      else if (!rd_inc && rd_dec) rd_out <= rd_out - RD_W'(1);
      if (i_rd_done && (rd_out == '0)) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_req_queue.sv
// Directed testbench for cpu_req_queue (default parameters).
// Bypass-specific expectations follow CPU_REQ_BYPASS_EN.
module tb_cpu_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [26:0] req_addr;
  logic [63:0] req_wdata;
  logic        ctl_valid;
  logic        ctl_ready;
  logic        ctl_wr;
  logic [26:0] ctl_addr;
  logic [63:0] ctl_wdata;
  logic        rd_done;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [2:0]  rd_out;
  logic        rd_err;

  int n_checks = 0;
  int n_errs   = 0;

  cpu_req_queue #(
    .ADDR_W(27),
    .DATA_W(64),
    .DEPTH(8),
    .MAX_RD_OUT(4)
  ) dut (
    .i_cpu_ck(clk),
    .i_cpu_reset(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_wr(req_wr),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_ctl_valid(ctl_valid),
    .i_ctl_ready(ctl_ready),
    .o_ctl_wr(ctl_wr),
    .o_ctl_addr(ctl_addr),
    .o_ctl_wdata(ctl_wdata),
    .i_rd_done(rd_done),
    .o_count(count),
    .o_full(full),
    .o_empty(empty),
    .o_rd_out(rd_out),
    .o_rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned q_addr[$];
  logic exp_pop;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    ctl_ready = 1'b0; rd_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_ctl_valid", ctl_valid, 0);
    chk("rst_ctl_wr", ctl_wr, 0);
    chk("rst_ctl_addr", ctl_addr, 0);
    chk("rst_ctl_wdata", ctl_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_rd_err", rd_err, 0);

    // Fill with 8 writes while the controller stalls
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 27'(i); req_wdata = 64'h1000 + 64'(i);
      #1;
`ifndef CPU_REQ_BYPASS_EN
      if (i == 0) chk("no_bypass_valid", ctl_valid, 0);
`endif
      tick();
      if (i == 0) begin
        chk("fill_lat_valid", ctl_valid, 1);
        chk("fill_lat_addr", ctl_addr, 0);
      end
    end
    req_valid = 1'b0;
    #1;
    chk("fill_full", full, 1);
    chk("fill_ready", req_ready, 0);
    chk("fill_count", count, 8);
    ctl_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0) chk("full_pop_ready_low", req_ready, 0);
      chk("drain_valid", ctl_valid, 1);
      chk("drain_wr", ctl_wr, 1);
      chk("drain_addr", ctl_addr, 64'(i));
      chk("drain_wdata", ctl_wdata, 64'h1000 + 64'(i));
      tick();
      if (i == 0) chk("ready_after_pop", req_ready, 1);
    end
    ctl_ready = 1'b0;
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_idle", ctl_valid, 0);
    chk("drain_idle_addr", ctl_addr, 0);

    // Read throttle: 6 reads, only 4 may be outstanding
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 27'(32 + i); req_wdata = '0;
      tick();
    end
    req_valid = 1'b0;
    chk("thr_count6", count, 6);
    ctl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("thr_valid", ctl_valid, 1);
      chk("thr_wr", ctl_wr, 0);
      chk("thr_addr", ctl_addr, 64'(32 + i));
      tick();
    end
    chk("thr_rd_out4", rd_out, 4);
    chk("thr_blocked", ctl_valid, 0);
    chk("thr_count2", count, 2);
    tick();
    chk("thr_still_blocked", ctl_valid, 0);
    rd_done = 1'b1;
    #1;
    chk("thr_no_lookahead", ctl_valid, 0);
    tick();
    rd_done = 1'b0;
    #1;
    chk("thr_rd_out3", rd_out, 3);
    chk("thr_unblock_valid", ctl_valid, 1);
    chk("thr_unblock_addr", ctl_addr, 64'h24);
    tick();
    chk("thr_rd_out4b", rd_out, 4);
    chk("thr_count1", count, 1);

    // Head-of-line: blocked read 0x25 with write 0xABCD behind it
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 27'hABCD; req_wdata = 64'hABCD;
    tick();
    req_valid = 1'b0;
    chk("hol_count", count, 2);
    chk("hol_blocked", ctl_valid, 0);
    tick();
    chk("hol_blocked2", ctl_valid, 0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    #1;
    chk("hol_read_valid", ctl_valid, 1);
    chk("hol_read_wr", ctl_wr, 0);
    chk("hol_read_addr", ctl_addr, 64'h25);
    // Read issue together with a completion: counter unchanged
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("sim_rd_out", rd_out, 3);
    chk("hol_write_valid", ctl_valid, 1);
    chk("hol_write_wr", ctl_wr, 1);
    chk("hol_write_addr", ctl_addr, 64'hABCD);
    chk("hol_write_wdata", ctl_wdata, 64'hABCD);
    tick();
    chk("hol_empty", empty, 1);
    chk("hol_rd_out3", rd_out, 3);
    rd_done = 1'b1;
    tick(); tick(); tick();
    rd_done = 1'b0;
    chk("rd_out_drained", rd_out, 0);
    chk("no_err_yet", rd_err, 0);

    // Simultaneous push and pop at count 3
    ctl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 27'(48 + i); req_wdata = 64'(i);
      tick();
    end
    chk("pp_count3", count, 3);
    req_addr = 27'h33; ctl_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pp_count_same", count, 3);
    chk("pp_head", ctl_addr, 64'h31);
    tick(); tick(); tick();
    chk("pp_empty", empty, 1);

    // Wrap: 20 interleaved cycles against a reference queue, then drain
    q_addr.delete();
    for (int k = 0; k < 28; k++) begin
      req_valid = (k < 20) && (k % 3 != 2);
      ctl_ready = (k >= 20) || (k % 2 == 1);
      req_wr = 1'b1; req_addr = 27'(64 + k); req_wdata = 64'(k);
      #1;
      if (req_valid && q_addr.size() < 8) q_addr.push_back(64 + k);
`ifdef CPU_REQ_BYPASS_EN
      exp_pop = (q_addr.size() > 0);
`else
      exp_pop = (q_addr.size() > 0) && !(req_valid && q_addr.size() == 1 && count == 0);
      if (req_valid && count == 0) begin
        chk("wrap_nobypass", ctl_valid, 0);
        exp_pop = 1'b0;
      end
`endif
      if (exp_pop) begin
        chk("wrap_valid", ctl_valid, 1);
        chk("wrap_addr", ctl_addr, 64'(q_addr[0]));
        if (ctl_ready) void'(q_addr.pop_front());
      end
      tick();
      chk("wrap_count", count, 64'(q_addr.size()));
    end
    req_valid = 1'b0;
    chk("wrap_empty", empty, 1);

    // Spurious completion sets the sticky error flag
    ctl_ready = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("err_set", rd_err, 1);
    chk("err_rd_out0", rd_out, 0);
    tick(); tick();
    chk("err_held", rd_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_clr", rd_err, 0);

    // Empty-queue write to 0x100 with the controller ready
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 27'h100; req_wdata = 64'h55; ctl_ready = 1'b1;
    #1;
`ifdef CPU_REQ_BYPASS_EN
    chk("byp_valid", ctl_valid, 1);
    chk("byp_addr", ctl_addr, 64'h100);
    tick();
    req_valid = 1'b0;
    chk("byp_count0", count, 0);
`else
    chk("nobyp_valid", ctl_valid, 0);
    tick();
    req_valid = 1'b0;
    chk("nobyp_count1", count, 1);
    chk("nobyp_addr", ctl_addr, 64'h100);
    tick();
    chk("nobyp_empty", empty, 1);
`endif

    // Reset with 3 entries stored
    ctl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 27'(80 + i);
      tick();
    end
    req_valid = 1'b0;
    chk("rst3_count", count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst3_empty", empty, 1);
    chk("rst3_valid", ctl_valid, 0);
    chk("rst3_count0", count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
